// File: rtl/alu_func_pkg.sv
// Shared ALU func encoding: op codes, one-hot func bytes, FSM states.
// Imported by the encoder, its FIFO and the ALU control decoder.
package alu_func_pkg;

  localparam logic [2:0] OP_MOVE = 3'd0;
  localparam logic [2:0] OP_ADD  = 3'd1;
  localparam logic [2:0] OP_SUB  = 3'd2;
  localparam logic [2:0] OP_AND  = 3'd3;
  localparam logic [2:0] OP_OR   = 3'd4;
  localparam logic [2:0] OP_NOT  = 3'd5;
  localparam logic [2:0] OP_NOP  = 3'd6;
  localparam logic [2:0] OP_ILL  = 3'd7;

  localparam logic [7:0] MOVEF = 8'h01;
  localparam logic [7:0] ADDF  = 8'h02;
  localparam logic [7:0] SUBF  = 8'h04;
  localparam logic [7:0] ANDF  = 8'h08;
  localparam logic [7:0] ORF   = 8'h10;
  localparam logic [7:0] NOTF  = 8'h20;
  localparam logic [7:0] NOPF  = 8'h40;
  localparam logic [7:0] WNDF  = 8'h80;

  // FIFO entry: {op[2:0], wndEn, wnd[1:0]}
  localparam int ENTRY_W = 6;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_WND  = 2'd1;
  localparam state_t S_OP   = 2'd2;

  // Illegal op is issued as NOP.
  function automatic logic [7:0] op_func(
    input logic [2:0] op
  );
    logic [7:0] f;
    f = NOPF;
    unique case (1'b1)
      (op == OP_MOVE): f = MOVEF;
      (op == OP_ADD):  f = ADDF;
      (op == OP_SUB):  f = SUBF;
      (op == OP_AND):  f = ANDF;
      (op == OP_OR):   f = ORF;
      (op == OP_NOT):  f = NOTF;
      (op == OP_NOP):  f = NOPF;
      (op == OP_ILL):  f = NOPF;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/alu_func_fifo.sv
// Synchronous request FIFO, DEPTH x W bits, first-word fall-through.
// Ports: clk, rst, push/din, pop/dout, full, empty, level.
module alu_func_fifo
  import alu_func_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = ENTRY_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [W-1:0]  din,
  input  logic          pop,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign full    = (cnt == (AW+1)'(DEPTH));
  assign empty   = (cnt == '0);
  assign level   = cnt;
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/alu_func_encoder.sv
// Buffers ALU op requests and issues one-hot func bytes, with WND bytes.
// Ports: req* (in, valid/ready), func* (out, valid/ready), curWnd, level,
// errOp. Macro ALU_FUNC_ENC_WND_COALESCE_EN suppresses redundant WND bytes.
module alu_func_encoder
  import alu_func_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reqValid,
  output logic        reqReady,
  input  logic [2:0]  reqOp,
  input  logic        reqWndEn,
  input  logic [1:0]  reqWnd,
  output logic        funcValid,
  input  logic        funcReady,
  output logic [7:0]  func,
  output logic [1:0]  curWnd,
  output logic [AW:0] level,
  output logic        errOp
);

  logic               full;
  logic               empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;
  logic [2:0]         head_op;
  logic               head_wen;
  logic [1:0]         head_wnd;
  logic               head_sw;

  state_t     state;
  logic [2:0] hold_op;
  logic [1:0] hold_wnd;
  logic [7:0] func_q;
  logic       valid_q;
  logic [1:0] wnd_q;
  logic       err_q;

  assign reqReady  = !full;
  assign push      = reqValid && !full;
  assign funcValid = valid_q;
  assign func      = func_q;
  assign curWnd    = wnd_q;
  assign errOp     = err_q;

  assign {head_op, head_wen, head_wnd} = head;

  // wnd_q is only updated by a WND handshake, never on a load edge,
  // so comparing against it here sees the last issued window.
`ifdef ALU_FUNC_ENC_WND_COALESCE_EN
  assign head_sw = head_wen && (head_wnd != wnd_q);
`else
  assign head_sw = head_wen;
`endif

  // Load next entry from idle, or right behind an op byte handshake.
  assign pop = !empty
            && ((state == S_IDLE)
             || ((state == S_OP) && funcReady));

  alu_func_fifo #(
    .DEPTH (DEPTH),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({reqOp, reqWndEn, reqWnd}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .level (level)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      hold_op  <= OP_NOP;
      hold_wnd <= 2'd0;
      func_q   <= NOPF;
      valid_q  <= 1'b0;
      wnd_q    <= 2'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= push && (reqOp == OP_ILL);
      if (pop) begin
        hold_op  <= head_op;
        hold_wnd <= head_wnd;
        valid_q  <= 1'b1;
        if (head_sw) begin
          state  <= S_WND;
          func_q <= WNDF | {6'd0, head_wnd};
        end else begin
          state  <= S_OP;
          func_q <= op_func(head_op);
        end
      end else if ((state == S_WND) && funcReady) begin
        wnd_q  <= hold_wnd;
        func_q <= op_func(hold_op);
        state  <= S_OP;
      end else if ((state == S_OP) && funcReady) begin
        state   <= S_IDLE;
        valid_q <= 1'b0;
      end
    end
  end

endmodule
